apb2axi_tag_sched: RTL and testbench

Per-tag lifecycle controller and issue scheduler for the APB2AXI converter.
- Allocates transaction tags to the APB register front-end.
- Tracks each tag through allocate, commit, issue, complete and release.
- Picks committed tags round-robin and presents them to the AXI request builder.
- Sits between the APB register block, the directory RAM, the AXI builder and the response/completion path.

---
 rtl/apb2axi_tag_sched.sv | 111 +++++++++++
 tb/tb_apb2axi_tag_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_tag_sched.sv
// apb2axi_tag_sched: per-tag lifecycle tracking with lowest-free allocation and round-robin issue
module apb2axi_tag_sched #(
  parameter int TAG_NUM = 16,
  parameter int TAG_W = $clog2(TAG_NUM)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             commit_is_write,
  output logic             issue_valid,
  output logic [TAG_W-1:0] issue_tag,
  output logic             issue_is_write,
  input  logic             issue_ready,
  input  logic             cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  input  logic [TAG_W-1:0] query_tag,
  output logic [1:0]       query_state,
  output logic [TAG_W:0]   free_cnt,
  output logic             err_pulse
);
  typedef enum logic [1:0] {ST_EMPTY, ST_ALLOCATED, ST_PENDING, ST_COMPLETE} entry_state_e;
  localparam logic [2:0] S_EMPTY = 3'd0, S_ALLOC = 3'd1, S_PEND = 3'd2, S_ISSUED = 3'd3, S_CPL = 3'd4;
  logic [TAG_NUM-1:0][2:0] st_q, st_d;
  logic [TAG_NUM-1:0] wr_q, wr_d, pend_m;
  logic [TAG_W-1:0] rr_q, rr_d, issue_tag_q, issue_tag_d, cand;
  logic issue_valid_q, issue_valid_d, issue_is_write_q, issue_is_write_d, err_q, err_d;
  logic [TAG_W:0] free_cnt_q, free_cnt_d;
  logic any_empty, cand_ok, hs, load, cmt_ok, cpl_ok, rel_ok;
  logic [2:0] qs;
  always_comb begin
    any_empty = 1'b0;
    alloc_tag = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--)
      if (st_q[i] == S_EMPTY) begin
        any_empty = 1'b1;
        alloc_tag = TAG_W'(i);
      end
  end
  assign alloc_gnt = alloc_req & any_empty;
  assign hs = issue_valid_q & issue_ready;
  assign load = ~issue_valid_q | hs;
  assign cmt_ok = commit_valid && st_q[commit_tag] == S_ALLOC;
  assign cpl_ok = cpl_valid && st_q[cpl_tag] == S_ISSUED;
  assign rel_ok = rel_valid && st_q[rel_tag] == S_CPL;
  // the tag leaving on this handshake is still PEND in the registered state, so mask it out
  for (genvar i = 0; i < TAG_NUM; i++) begin : g_pend
    assign pend_m[i] = st_q[i] == S_PEND && !(hs && issue_tag_q == TAG_W'(i));
  end
  always_comb begin
    cand_ok = 1'b0;
    cand = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--)
      if (pend_m[rr_q + TAG_W'(i)]) begin
        cand_ok = 1'b1;
        cand = rr_q + TAG_W'(i);
      end
  end
  always_comb begin
    st_d = st_q;
    wr_d = wr_q;
    if (alloc_gnt) st_d[alloc_tag] = S_ALLOC;
    if (cmt_ok) begin
      st_d[commit_tag] = S_PEND;
      wr_d[commit_tag] = commit_is_write;
    end
    if (hs) st_d[issue_tag_q] = S_ISSUED;
    if (cpl_ok) st_d[cpl_tag] = S_CPL;
    if (rel_ok) st_d[rel_tag] = S_EMPTY;
  end
  always_comb begin
    issue_valid_d = load ? cand_ok : issue_valid_q;
    issue_tag_d = load && cand_ok ? cand : issue_tag_q;
    issue_is_write_d = load && cand_ok ? wr_q[cand] : issue_is_write_q;
    rr_d = load && cand_ok ? cand + 1'b1 : rr_q;
    free_cnt_d = free_cnt_q + (TAG_W+1)'(rel_ok) - (TAG_W+1)'(alloc_gnt);
    err_d = (commit_valid & ~cmt_ok) | (cpl_valid & ~cpl_ok) | (rel_valid & ~rel_ok);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      st_q <= '0;
      wr_q <= '0;
      rr_q <= '0;
      issue_valid_q <= 1'b0;
      issue_tag_q <= '0;
      issue_is_write_q <= 1'b0;
      free_cnt_q <= (TAG_W+1)'(TAG_NUM);
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wr_q <= wr_d;
      rr_q <= rr_d;
      issue_valid_q <= issue_valid_d;
      issue_tag_q <= issue_tag_d;
      issue_is_write_q <= issue_is_write_d;
      free_cnt_q <= free_cnt_d;
      err_q <= err_d;
    end
  assign qs = st_q[query_tag];
  assign query_state = qs == S_EMPTY ? ST_EMPTY : qs == S_ALLOC ? ST_ALLOCATED : qs == S_CPL ? ST_COMPLETE : ST_PENDING;
  assign issue_valid = issue_valid_q;
  assign issue_tag = issue_tag_q;
  assign issue_is_write = issue_is_write_q;
  assign free_cnt = free_cnt_q;
  assign err_pulse = err_q;
endmodule

// File: tb/tb_apb2axi_tag_sched.sv
// tb_apb2axi_tag_sched: directed scenarios plus random traffic against a per-tag lifecycle model
module tb_apb2axi_tag_sched;
  localparam int N = 16, W = 4;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic alloc_req, alloc_gnt, commit_valid, commit_is_write, issue_valid, issue_is_write, issue_ready;
  logic cpl_valid, rel_valid, err_pulse;
  logic [W-1:0] alloc_tag, commit_tag, issue_tag, cpl_tag, rel_tag, query_tag;
  logic [1:0] query_state;
  logic [W:0] free_cnt;
  int n_tot = 0, n_bad = 0;
  int ms[N];
  bit mw[N];
  int mrr, mit, mfc;
  bit miv, miw, merr;
  int q_iss[$];
  always #5 aclk = ~aclk;
  apb2axi_tag_sched #(.TAG_NUM(N)) dut (
    .aclk(aclk), .aresetn(aresetn), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_is_write(commit_is_write),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_is_write(issue_is_write), .issue_ready(issue_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .rel_valid(rel_valid), .rel_tag(rel_tag),
    .query_tag(query_tag), .query_state(query_state), .free_cnt(free_cnt), .err_pulse(err_pulse)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  // lifecycle codes: 0 empty, 1 allocated, 2 pending, 3 issued, 4 complete
  function automatic int qmap(input int s);
    return s == 0 ? 0 : s == 1 ? 1 : s == 4 ? 3 : 2;
  endfunction
  function automatic int low_empty();
    for (int i = 0; i < N; i++) if (ms[i] == 0) return i;
    return -1;
  endfunction
  function automatic int pick(input int s);
    int q[$];
    foreach (ms[i]) if (ms[i] == s) q.push_back(i);
    return q.size() > 0 ? q[$urandom_range(0, q.size() - 1)] : -1;
  endfunction
  task automatic m_reset();
    foreach (ms[i]) begin
      ms[i] = 0;
      mw[i] = 0;
    end
    mrr = 0; mit = 0; mfc = N; miv = 0; miw = 0; merr = 0;
  endtask
  task automatic mstep();
    int ns[N];
    int a;
    bit hs, bad, found;
    ns = ms;
    hs = miv && issue_ready;
    a = low_empty();
    bad = 0;
    if (alloc_req && a >= 0) begin
      ns[a] = 1;
      mfc--;
    end
    if (commit_valid) begin
      if (ms[commit_tag] == 1) begin
        ns[commit_tag] = 2;
        mw[commit_tag] = commit_is_write;
      end else bad = 1;
    end
    if (hs) ns[mit] = 3;
    if (cpl_valid) begin
      if (ms[cpl_tag] == 3) ns[cpl_tag] = 4;
      else bad = 1;
    end
    if (rel_valid) begin
      if (ms[rel_tag] == 4) begin
        ns[rel_tag] = 0;
        mfc++;
      end else bad = 1;
    end
    if (!miv || hs) begin
      found = 0;
      for (int k = 0; k < N && !found; k++) begin
        int t = (mrr + k) % N;
        if (ms[t] == 2 && !(hs && t == mit)) begin
          found = 1;
          mit = t;
          miw = mw[t];
          mrr = (t + 1) % N;
        end
      end
      miv = found;
    end
    merr = bad;
    ms = ns;
  endtask
  task automatic cyc();
    int a;
    bit g;
    #1;
    a = low_empty();
    g = alloc_req && a >= 0;
    chk("alloc_gnt", alloc_gnt, g);
    if (g) chk("alloc_tag", alloc_tag, a);
    chk("issue_valid", issue_valid, miv);
    if (miv) begin
      chk("issue_tag", issue_tag, mit);
      chk("issue_is_write", issue_is_write, miw);
    end
    chk("free_cnt", free_cnt, mfc);
    chk("err_pulse", err_pulse, merr);
    chk("query_state", query_state, qmap(ms[query_tag]));
    if (issue_valid && issue_ready) q_iss.push_back(int'(issue_tag));
    @(posedge aclk);
    mstep();
    @(negedge aclk);
  endtask
  task automatic rnd_ev(input int s, output logic v, output logic [W-1:0] t);
    int p;
    v = 1'($urandom_range(0, 1));
    p = pick(s);
    t = (p >= 0 && $urandom_range(0, 7) != 0) ? W'(p) : W'($urandom_range(0, N - 1));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    {alloc_req, commit_valid, commit_tag, commit_is_write, issue_ready, cpl_valid, cpl_tag, rel_valid, rel_tag, query_tag} = '0;
    m_reset();
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_tag", issue_tag, 0);
    chk("rst_issue_wr", issue_is_write, 0);
    chk("rst_free_cnt", free_cnt, N);
    chk("rst_err", err_pulse, 0);
    chk("rst_query", query_state, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    alloc_req = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1 chk("fill_tag", alloc_tag, i);
      cyc();
    end
    #1 chk("full_gnt", alloc_gnt, 0);
    cyc();
    alloc_req = 1'b0;
    chk("full_err", err_pulse, 0);
    chk("full_cnt", free_cnt, 0);
    issue_ready = 1'b1;
    commit_valid = 1'b1; commit_tag = 4'd1; commit_is_write = 1'b1;
    cyc();
    commit_tag = 4'd0; commit_is_write = 1'b0;
    cyc();
    commit_valid = 1'b0;
    chk("lat_valid1", issue_valid, 1);
    chk("lat_tag1", issue_tag, 1);
    chk("lat_wr1", issue_is_write, 1);
    cyc();
    chk("b2b_valid0", issue_valid, 1);
    chk("b2b_tag0", issue_tag, 0);
    chk("b2b_wr0", issue_is_write, 0);
    cyc();
    issue_ready = 1'b0;
    commit_valid = 1'b1; commit_tag = 4'd5; commit_is_write = 1'b1;
    cyc();
    commit_valid = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      commit_valid = k < 2;
      commit_tag = k == 0 ? 4'd2 : 4'd9;
      commit_is_write = 1'($urandom_range(0, 1));
      chk("stall_valid", issue_valid, 1);
      chk("stall_tag", issue_tag, 5);
      cyc();
    end
    commit_valid = 1'b0;
    issue_ready = 1'b1;
    q_iss.delete();
    repeat (4) cyc();
    issue_ready = 1'b0;
    chk("rr_count", q_iss.size(), 3);
    chk("rr_first", q_iss[0], 5);
    chk("rr_wrap", q_iss[1], 9);
    chk("rr_last", q_iss[2], 2);
    cpl_valid = 1'b1; cpl_tag = 4'd3; rel_valid = 1'b1; rel_tag = 4'd1;
    cyc();
    cpl_valid = 1'b0; rel_valid = 1'b0;
    chk("ill_err", err_pulse, 1);
    query_tag = 4'd3;
    #1 chk("ill_q3", query_state, 1);
    query_tag = 4'd1;
    #1 chk("ill_q1", query_state, 2);
    cyc();
    chk("ill_once", err_pulse, 0);
    cpl_valid = 1'b1; cpl_tag = 4'd0;
    cyc();
    cpl_valid = 1'b0; rel_valid = 1'b1; rel_tag = 4'd0;
    cyc();
    rel_valid = 1'b0;
    commit_valid = 1'b1; commit_tag = 4'd3; issue_ready = 1'b1;
    cyc();
    commit_valid = 1'b0;
    repeat (2) cyc();
    issue_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 4'd3;
    cyc();
    cpl_valid = 1'b0;
    rel_valid = 1'b1; rel_tag = 4'd3; alloc_req = 1'b1;
    #1 chk("life_gnt", alloc_gnt, 1);
    chk("life_new_tag", alloc_tag, 0);
    cyc();
    rel_valid = 1'b0; alloc_req = 1'b0;
    chk("life_cnt", free_cnt, 1);
    query_tag = 4'd3;
    #1 chk("life_q3", query_state, 0);
    commit_valid = 1'b1; commit_tag = 4'd4;
    cyc();
    commit_valid = 1'b0;
    cyc();
    chk("arst_pre", issue_valid, 1);
    #2 aresetn = 1'b0;
    #1 chk("arst_valid", issue_valid, 0);
    m_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    chk("arst_cnt", free_cnt, N);
    for (int c = 0; c < 3000; c++) begin
      alloc_req = 1'($urandom_range(0, 1));
      rnd_ev(1, commit_valid, commit_tag);
      commit_is_write = 1'($urandom_range(0, 1));
      rnd_ev(3, cpl_valid, cpl_tag);
      rnd_ev(4, rel_valid, rel_tag);
      issue_ready = $urandom_range(0, 3) != 0;
      query_tag = W'($urandom_range(0, N - 1));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
